// File: rtl/alu_seq.sv
// Handshaked sequential ALU with internal NZCV register, bit-serial shifts/rotates.
// Optional shift-add multiplier on opcode 5'h10 when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int SHW        = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            opcode,
    input  logic                  op_sel,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [SHW-1:0]        shamt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Y,
    output logic [3:0]            flags
);
    localparam int MSB = DATA_WIDTH - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

    state_t          state, state_nxt;
    logic [SHW-1:0]  cnt;
    logic [MSB:0]    w;
    logic            cs;
    logic [1:0]      kind;
    logic            dir;
    logic [MSB:0]    x;
    logic            accept;
    logic            is_shift;
    logic            is_mul;
    logic [MSB:0]    imm_y;
    logic            imm_c;
    logic            imm_v;
    logic [DATA_WIDTH:0] step;

    // Returns {C, V, Y}; u tracks carry/borrow, s is the exact signed result.
    function automatic logic [DATA_WIDTH+1:0] arith(input logic [MSB:0] a, input logic [MSB:0] b,
                                                    input logic cin, input logic sub);
        logic [DATA_WIDTH:0]        u;
        logic signed [DATA_WIDTH:0] s;
        logic [DATA_WIDTH:0]        ci;
        ci = {{DATA_WIDTH{1'b0}}, cin};
        if (sub) begin
            u = {1'b0, a} - {1'b0, b} - ci;
            s = $signed({a[MSB], a}) - $signed({b[MSB], b}) - $signed(ci);
        end else begin
            u = {1'b0, a} + {1'b0, b} + ci;
            s = $signed({a[MSB], a}) + $signed({b[MSB], b}) + $signed(ci);
        end
        return {u[DATA_WIDTH], s[DATA_WIDTH] ^ s[DATA_WIDTH-1], u[MSB:0]};
    endfunction

    function automatic logic [3:0] mk_flags(input logic [MSB:0] y, input logic c, input logic v);
        return {y[MSB], (y == '0), c, v};
    endfunction

    // One-bit step; kind: 0 ASH, 1 LSH, 2 ROT, 3 RCC. Returns {carry_out, w}.
    function automatic logic [DATA_WIDTH:0] shift_step(input logic [1:0] k, input logic left,
                                                       input logic [MSB:0] v, input logic c);
        logic fill;
        fill = 1'b0;
        if (left) begin
            case (k)
                2'd2:    fill = v[MSB];
                2'd3:    fill = c;
                default: fill = 1'b0;
            endcase
            return {v[MSB], v[MSB-1:0], fill};
        end
        case (k)
            2'd0:    fill = v[MSB];
            2'd1:    fill = 1'b0;
            2'd2:    fill = v[0];
            default: fill = c;
        endcase
        return {v[0], fill, v[MSB:1]};
    endfunction

    assign x         = op_sel ? A : B;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign is_shift  = (opcode[4:2] == 3'b011);
    assign step      = shift_step(kind, dir, w, cs);

`ifdef ALU_SEQ_MUL_EN
    logic [2*DATA_WIDTH-1:0] p;
    logic [2*DATA_WIDTH-1:0] mul_nxt;
    logic [MSB:0]            mcand;
    logic [DATA_WIDTH:0]     mul_sum;

    assign is_mul  = (opcode == 5'h10);
    assign mul_sum = {1'b0, p[2*DATA_WIDTH-1:DATA_WIDTH]} + (p[0] ? {1'b0, mcand} : '0);
    assign mul_nxt = {mul_sum, p[MSB:1]};
`else
    assign is_mul  = 1'b0;
`endif

    // Single-cycle results for ops 0-B and zero-amount shifts
    always_comb begin
        imm_y = '0;
        imm_c = 1'b0;
        imm_v = 1'b0;
        case (opcode[3:0])
            4'h0: {imm_c, imm_v, imm_y} = arith(A, B, 1'b0, 1'b0);
            4'h1: {imm_c, imm_v, imm_y} = arith(A, B, flags[1], 1'b0);
            4'h2: {imm_c, imm_v, imm_y} = arith(A, B, 1'b0, 1'b1);
            4'h3: {imm_c, imm_v, imm_y} = arith(A, B, flags[1], 1'b1);
            4'h4: {imm_c, imm_v, imm_y} = arith('0, x, 1'b0, 1'b1);
            4'h5: {imm_c, imm_v, imm_y} = arith(x, '0, 1'b1, 1'b0);
            4'h6: {imm_c, imm_v, imm_y} = arith(x, '0, 1'b1, 1'b1);
            4'h7: imm_y = x;
            4'h8: imm_y = A & B;
            4'h9: imm_y = A | B;
            4'hA: imm_y = A ^ B;
            4'hB: imm_y = ~x;
            default: begin
                imm_y = x;
                imm_c = flags[1];
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (opcode[4])                          state_nxt = is_mul ? MUL : DONE;
                    else if (is_shift && (shamt != '0))     state_nxt = SHIFT;
                    else                                    state_nxt = DONE;
                end
            end
            SHIFT:   if (cnt == SHW'(1)) state_nxt = DONE;
            MUL:     if (cnt == '0)      state_nxt = DONE;
            DONE:    if (out_ready)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Architected outputs and counter: committed only at the end of an op
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Y     <= '0;
            flags <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (opcode[4]) begin
                            if (is_mul) cnt <= SHW'(DATA_WIDTH - 1);
                            else        Y   <= '0;
                        end else if (is_shift && (shamt != '0)) begin
                            cnt <= shamt;
                        end else begin
                            Y     <= imm_y;
                            flags <= mk_flags(imm_y, imm_c, imm_v);
                        end
                    end
                end
                SHIFT: begin
                    cnt <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        Y     <= step[MSB:0];
                        flags <= mk_flags(step[MSB:0], step[DATA_WIDTH], 1'b0);
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - SHW'(1);
                    end else begin
                        Y     <= mul_nxt[MSB:0];
                        flags <= mk_flags(mul_nxt[MSB:0], |mul_nxt[2*DATA_WIDTH-1:DATA_WIDTH], 1'b0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Working registers: loaded on every accept, meaningful only in SHIFT/MUL
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            w    <= x;
            cs   <= flags[1];
            kind <= opcode[1:0];
            dir  <= op_sel;
`ifdef ALU_SEQ_MUL_EN
            p     <= {{DATA_WIDTH{1'b0}}, B};
            mcand <= A;
`endif
        end else if (state == SHIFT) begin
            {cs, w} <= step;
        end
`ifdef ALU_SEQ_MUL_EN
        else if (state == MUL) begin
            p <= mul_nxt;
        end
`endif
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table driven through a result scoreboard,
// plus backpressure and mid-operation reset sequences.
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] opcode = '0;
    logic       op_sel = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic [2:0] shamt = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] Y;
    logic [3:0] flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] y;
        logic [3:0] f;
        int         lat;
    } exp_t;

    typedef struct {
        logic [4:0] opc;
        logic       sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sh;
        logic [7:0] y;
        logic [3:0] f;
        int         lat;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];

    alu_seq #(.DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .op_sel(op_sel), .A(A), .B(B), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        exp_t e;
        int   lat;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        opcode   = v.opc;
        op_sel   = v.sel;
        A        = v.a;
        B        = v.b;
        shamt    = v.sh;
        in_valid = 1'b1;
        sb.push_back('{v.y, v.f, v.lat});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = 8'($urandom);
        B        = 8'($urandom);
        shamt    = 3'($urandom);
        op_sel   = 1'($urandom);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout op %0h: no out_valid after %0d cycles", v.opc, lat);
        end else begin
            chk($sformatf("Y op%0h", v.opc), Y, e.y);
            chk($sformatf("flags op%0h", v.opc), flags, e.f);
            chk($sformatf("latency op%0h", v.opc), lat, e.lat);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after_hs", in_ready, 1);
        chk("out_valid_after_hs", out_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        vec_t bp;

        vt.push_back('{5'h00, 1'b1, 8'hFF, 8'h01, 3'd0, 8'h00, 4'b0110, 1});
        vt.push_back('{5'h01, 1'b1, 8'h10, 8'h20, 3'd0, 8'h31, 4'b0000, 1});
        vt.push_back('{5'h02, 1'b1, 8'h80, 8'h01, 3'd0, 8'h7F, 4'b0001, 1});
        vt.push_back('{5'h04, 1'b1, 8'h80, 8'h00, 3'd0, 8'h80, 4'b1011, 1});
        vt.push_back('{5'h03, 1'b1, 8'h05, 8'h03, 3'd0, 8'h01, 4'b0000, 1});
        vt.push_back('{5'h03, 1'b1, 8'h00, 8'h01, 3'd0, 8'hFF, 4'b1010, 1});
        vt.push_back('{5'h01, 1'b1, 8'h7F, 8'h00, 3'd0, 8'h80, 4'b1001, 1});
        vt.push_back('{5'h05, 1'b0, 8'h12, 8'hFF, 3'd0, 8'h00, 4'b0110, 1});
        vt.push_back('{5'h06, 1'b1, 8'h00, 8'h55, 3'd0, 8'hFF, 4'b1010, 1});
        vt.push_back('{5'h06, 1'b1, 8'h80, 8'h55, 3'd0, 8'h7F, 4'b0001, 1});
        vt.push_back('{5'h08, 1'b1, 8'hF0, 8'h3C, 3'd0, 8'h30, 4'b0000, 1});
        vt.push_back('{5'h0A, 1'b1, 8'hF0, 8'h3C, 3'd0, 8'hCC, 4'b1000, 1});
        vt.push_back('{5'h0B, 1'b0, 8'h00, 8'hFF, 3'd0, 8'h00, 4'b0100, 1});
        vt.push_back('{5'h07, 1'b1, 8'h00, 8'h77, 3'd0, 8'h00, 4'b0100, 1});
        vt.push_back('{5'h0F, 1'b0, 8'h01, 8'h01, 3'd1, 8'h00, 4'b0110, 2});
        vt.push_back('{5'h0C, 1'b0, 8'h80, 8'h80, 3'd7, 8'hFF, 4'b1000, 8});
        vt.push_back('{5'h0E, 1'b1, 8'h81, 8'h00, 3'd1, 8'h03, 4'b0010, 2});
        vt.push_back('{5'h13, 1'b1, 8'hAA, 8'h55, 3'd3, 8'h00, 4'b0010, 1});
        vt.push_back('{5'h0D, 1'b1, 8'h01, 8'h00, 3'd0, 8'h01, 4'b0010, 1});
`ifdef ALU_SEQ_MUL_EN
        vt.push_back('{5'h10, 1'b1, 8'h10, 8'h10, 3'd0, 8'h00, 4'b0110, 9});
`else
        vt.push_back('{5'h10, 1'b1, 8'h10, 8'h10, 3'd0, 8'h00, 4'b0010, 1});
`endif
        vt.push_back('{5'h0D, 1'b0, 8'h00, 8'hF1, 3'd4, 8'h0F, 4'b0000, 5});
        vt.push_back('{5'h0F, 1'b1, 8'h80, 8'h00, 3'd2, 8'h01, 4'b0000, 3});
        vt.push_back('{5'h09, 1'b1, 8'hF0, 8'h3C, 3'd0, 8'hFC, 4'b1000, 1});

        repeat (2) @(negedge clk);
        chk("reset_Y", Y, 0);
        chk("reset_flags", flags, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) run_op(vt[i]);

        // Backpressure: hold out_ready low while a new request waits
        @(negedge clk);
        opcode = 5'h00; A = 8'hFF; B = 8'hFF; in_valid = 1'b1;
        sb.push_back('{8'hFE, 4'b1010, 1});
        @(posedge clk);
        #1;
        opcode = 5'h02; A = 8'h00; B = 8'h00;
        e = sb.pop_front();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_Y", Y, e.y);
            chk("bp_flags", flags, e.f);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_in_ready_return", in_ready, 1);
        chk("bp_out_valid_drop", out_valid, 0);

        // Reset in the third SHIFT cycle of a 7-bit LSH left
        @(negedge clk);
        opcode = 5'h0D; op_sel = 1'b1; A = 8'h01; shamt = 3'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_reset_busy", in_ready, 0);
        reset = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_Y", Y, 0);
        chk("abort_flags", flags, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("abort_no_result", out_valid, 0);
        end
        bp = '{5'h00, 1'b1, 8'h02, 8'h03, 3'd0, 8'h05, 4'b0000, 1};
        run_op(bp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked sequential ALU that replaces the fixed 8-bit single-cycle ALU in the CPU datapath. It keeps an internal NZCV status register, so the add-with-carry and rotate-through-carry ops take carry from state rather than from the instruction word. It performs shifts and rotates by a variable amount at one bit per cycle. It sits between operand fetch and writeback with valid/ready on both sides.

## Interface
- DATA_WIDTH, 8, operand/result width; power of 2, at least 4.
- SHW, $clog2(DATA_WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE.
- opcode  in  5  operation; encoding in Operation.
- op_sel  in  1  operand select for unary ops and shifts (1 = A, 0 = B); direction for shifts and rotates (1 = left).
- A, B  in  DATA_WIDTH  operands.
- shamt  in  SHW  shift/rotate amount.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed.
- Y  out  DATA_WIDTH  registered result.
- flags  out  4  {N,Z,C,V}, registered.

## Operation
Opcode map (opcode[4] = 0):
- 0 ADD; 1 ADC (+C flag); 2 SUB; 3 SBC (−C flag).
- 4 NEG = 0 − x; 5 INC; 6 DEC; 7 PASS. Here x = op_sel ? A : B.
- 8 AND; 9 OR; A XOR; B NOT x.
- C ASH: left shift, or right shift with sign fill. D LSH: logical shift. E ROT: rotate. F RCC: (DATA_WIDTH+1)-bit rotate through C.

Operands and C are captured on accept (in_valid && in_ready). Input changes while busy are ignored.

States:
- IDLE: on accept, go to DONE for ops 0–B and for shift ops with shamt = 0 (result = x, C unchanged). Otherwise load W = x and cnt = shamt, then go to SHIFT.
- SHIFT: each cycle, shift or rotate W by one bit and decrement cnt. When cnt reaches 1, commit and go to DONE.
- DONE: hold Y, flags and out_valid. When out_ready is high, go to IDLE.

Flags are written only on commit:
- N = Y[MSB]; Z = (Y == 0).
- ADD/ADC/INC: C = carry out; V = signed overflow.
- SUB/SBC/DEC: C = borrow (1 when the unsigned result is below 0); V = signed overflow.
- NEG: C = (x != 0); V = (x == 100…0).
- Logic ops and PASS: C = 0, V = 0.
- Shifts/rotates: C = last bit shifted or rotated out (RCC: the final carry); V = 0.

All arithmetic is modulo 2^DATA_WIDTH.

Illegal opcodes (opcode[4] = 1, except MUL when enabled): go to DONE with Y = 0 and flags unchanged.

## Timing
- Reset values: Y = 0, flags = 0, out_valid = 0, in_ready = 1, state = IDLE, cnt = 0.
- Op accepted in cycle N:
  - ops 0–B and shamt = 0: out_valid in cycle N+1.
  - shift with shamt = s > 0: out_valid in cycle N+1+s.
  - MUL: out_valid in cycle N+1+DATA_WIDTH.
- Back-to-back throughput is one op per 2 cycles minimum. in_ready returns in the cycle after the out_valid && out_ready handshake.
- out_valid stays high, with Y stable, until out_ready. out_ready while not in DONE is ignored.
- Reset asserted mid-SHIFT, mid-MUL or in DONE aborts the op: all outputs return to reset values immediately, and no result is emitted.

## Configuration
- ALU_SEQ_MUL_EN defined: opcode 5'h10 = MUL, an unsigned shift-add multiply over DATA_WIDTH cycles in a MUL state.
  - Y = low half of A×B.
  - C = OR of the high half; V = 0; N and Z from Y.
- ALU_SEQ_MUL_EN undefined: 5'h10 is illegal (Y = 0, flags unchanged, 1-cycle latency), and no multiplier logic is built.

## Test plan
- ADD A = 8'hFF, B = 8'h01 → Y = 8'h00, flags = {0,1,1,0}, out_valid one cycle after accept. Then ADC A = 8'h10, B = 8'h20 → Y = 8'h31, C = 0.
- SUB A = 8'h80, B = 8'h01 → Y = 8'h7F, V = 1, C = 0. NEG x = 8'h80 → Y = 8'h80, V = 1, C = 1.
- RCC right, A = 8'h01, shamt = 1, C = 0 → Y = 8'h00, C = 1, Z = 1, out_valid 2 cycles after accept. ASH right, A = 8'h80, shamt = 7 → Y = 8'hFF, out_valid 8 cycles after accept.
- Backpressure: out_ready low for 5 cycles → Y, flags and out_valid stable, in_ready = 0, and a held in_valid is not accepted. When out_ready rises, in_ready = 1 in the next cycle.
- Reset asserted in the 3rd SHIFT cycle of an LSH with shamt = 7 → out_valid = 0, Y = 0, flags = 0, in_ready = 1. A subsequent ADD completes normally.
- With ALU_SEQ_MUL_EN: MUL 8'h10 × 8'h10 → Y = 8'h00, C = 1, Z = 1, out_valid 9 cycles after accept. Without the macro → Y = 0, flags unchanged, 1-cycle latency.
